// File: rtl/usb_io_led.sv
// Board I/O demo controller: four synchronized switch inputs drive four LEDs
// through one of several functions chosen by a 4-bit mode bus.
module usb_io_led #(
  parameter int PRESCALE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] IO_mode,
  input  logic [3:0] IO_input,
  output logic [3:0] LED
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = SYNC_STAGES * 4;

  logic [SW-1:0] sync_r;
  logic [3:0]    prev_r;
  logic [3:0]    mode_q_r;
  logic [PW-1:0] presc_r;
  logic [3:0]    cnt_r;
  logic [3:0]    shreg_r;
  logic [3:0]    tog_r;
  logic [3:0]    ring_r;
  logic [3:0]    led_r;

  logic [3:0]    s_s;
  logic [3:0]    rise_s;
  logic          tick_s;
  logic          mode_chg_s;
  logic [3:0]    rot_s;
  logic [PW-1:0] presc_nxt_s;
  logic [3:0]    cnt_nxt_s;
  logic [3:0]    shreg_nxt_s;
  logic [3:0]    tog_nxt_s;
  logic [3:0]    ring_nxt_s;
  logic [3:0]    led_nxt_s;

  function automatic logic parity4(input logic [3:0] v);
    return ^v;
  endfunction

  assign s_s        = sync_r[SW-1 -: 4];
  assign rise_s     = s_s & ~prev_r;
  assign tick_s     = (presc_r == PW'(PRESCALE - 1));
  assign mode_chg_s = (IO_mode != mode_q_r);
  assign LED        = led_r;

  // Next-state and LED function selection
  always_comb begin
    presc_nxt_s = tick_s ? '0 : presc_r + PW'(1);
    cnt_nxt_s   = cnt_r;
    shreg_nxt_s = shreg_r;
    tog_nxt_s   = tog_r;
    ring_nxt_s  = ring_r;
    led_nxt_s   = 4'b0000;
    rot_s       = ring_r;
    if (mode_chg_s) begin
      presc_nxt_s = '0;
      cnt_nxt_s   = 4'd0;
      shreg_nxt_s = 4'b0000;
      tog_nxt_s   = 4'b0000;
      ring_nxt_s  = 4'b0001;
      led_nxt_s   = 4'b0000;
    end else if (!mode_q_r[3]) begin
      led_nxt_s = 4'b0000;
    end else begin
      case (mode_q_r[2:0])
        3'b000: led_nxt_s = s_s;
        3'b001: begin
          if (rise_s[0]) begin
            cnt_nxt_s = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
          led_nxt_s = cnt_nxt_s;
        end
        3'b010: begin
          if (rise_s[0]) begin
            shreg_nxt_s = {shreg_r[2:0], s_s[1]};
          end else begin
            shreg_nxt_s = shreg_r;
          end
          led_nxt_s = shreg_nxt_s;
        end
        3'b011: led_nxt_s = ~s_s;
        3'b100: begin
          if (tick_s) begin
            cnt_nxt_s = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
          led_nxt_s = cnt_r;
        end
        3'b101: begin
          tog_nxt_s = tog_r ^ rise_s;
          led_nxt_s = tog_nxt_s;
        end
        3'b110: led_nxt_s = {3'b000, parity4(s_s)};
        3'b111: begin
          // s[0] picks direction; an all-zero ring is forced back to a single lit LED
          if (tick_s) begin
            rot_s = s_s[0] ? {ring_r[0], ring_r[3:1]} : {ring_r[2:0], ring_r[3]};
          end else begin
            rot_s = ring_r;
          end
          ring_nxt_s = (rot_s == 4'b0000) ? 4'b0001 : rot_s;
          led_nxt_s  = ring_r;
        end
        default: led_nxt_s = 4'b0000;
      endcase
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r   <= '0;
      prev_r   <= 4'b0000;
      mode_q_r <= 4'b0000;
      presc_r  <= '0;
      cnt_r    <= 4'd0;
      shreg_r  <= 4'b0000;
      tog_r    <= 4'b0000;
      ring_r   <= 4'b0001;
      led_r    <= 4'b0000;
    end else begin
      sync_r   <= {sync_r[SW-5:0], IO_input};
      prev_r   <= s_s;
      mode_q_r <= IO_mode;
      presc_r  <= presc_nxt_s;
      cnt_r    <= cnt_nxt_s;
      shreg_r  <= shreg_nxt_s;
      tog_r    <= tog_nxt_s;
      ring_r   <= ring_nxt_s;
      led_r    <= led_nxt_s;
    end
  end

endmodule

// File: tb/tb_usb_io_led.sv
// Scoreboard bench for usb_io_led: a behavioural model predicts LED per edge,
// a monitor compares the DUT output on the falling edge.
module tb_usb_io_led;

  localparam int P  = 4;
  localparam int SS = 2;

  logic       clk;
  logic       reset;
  logic [3:0] IO_mode;
  logic [3:0] IO_input;
  logic [3:0] LED;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] exp_q[$];

  usb_io_led #(.PRESCALE(P), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .IO_mode(IO_mode), .IO_input(IO_input), .LED(LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: input history, counters as integers, ring as a position
  logic [3:0] hist[$];
  logic [3:0] m_mode;
  int m_presc, m_cnt, m_sh, m_pos;
  logic [3:0] m_tog;

  always @(posedge clk) begin
    logic [3:0] s, pv, rise, led;
    bit tick;
    cyc = cyc + 1;
    led = 4'b0000;
    if (!reset || hist.size() < SS + 1) begin
      hist.delete();
      for (int i = 0; i < SS + 1; i++) hist.push_back(4'b0000);
      m_mode = 4'b0000; m_presc = 0; m_cnt = 0; m_sh = 0; m_pos = 0; m_tog = 4'b0000;
      led = 4'b0000;
    end else begin
      s    = hist[SS - 1];
      pv   = hist[SS];
      rise = s & ~pv;
      if (IO_mode != m_mode) begin
        m_presc = 0; m_cnt = 0; m_sh = 0; m_pos = 0; m_tog = 4'b0000;
        led = 4'b0000;
      end else begin
        tick    = (m_presc == P - 1);
        m_presc = (m_presc + 1) % P;
        case (m_mode)
          4'b1000: led = s;
          4'b1001: begin
            if (rise[0]) m_cnt = (m_cnt + 1) % 16;
            led = 4'(m_cnt);
          end
          4'b1010: begin
            if (rise[0]) m_sh = (m_sh * 2 + int'(s[1])) % 16;
            led = 4'(m_sh);
          end
          4'b1011: led = ~s;
          4'b1100: begin
            led = 4'(m_cnt);
            if (tick) m_cnt = (m_cnt + 1) % 16;
          end
          4'b1101: begin
            m_tog = m_tog ^ rise;
            led = m_tog;
          end
          4'b1110: led = 4'($countones(s) % 2);
          4'b1111: begin
            led = 4'(1 << m_pos);
            if (tick) m_pos = s[0] ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
          end
          default: led = 4'b0000;
        endcase
      end
      m_mode = IO_mode;
      hist.push_front(IO_input);
      void'(hist.pop_back());
    end
    exp_q.push_back(led);
  end

  // Monitor: LED is presented every cycle, compared away from the rising edge
  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (LED !== e) begin
        errors = errors + 1;
        $display("FAIL led cycle=%0d mode=%b got=%b exp=%b", cyc, IO_mode, LED, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse0(input int rises, input logic [3:0] base);
    for (int i = 0; i < rises; i++) begin
      IO_input = base | 4'b0001; step(1);
      IO_input = base & 4'b1110; step(1);
    end
  endtask

  initial begin
    reset = 1'b0; IO_mode = 4'b1111; IO_input = 4'b0000;
    step(2);
    reset = 1'b1; step(20);
    IO_input = 4'b0001; step(12);

    IO_mode = 4'b1000; IO_input = 4'b1010; step(6);
    IO_mode = 4'b1011; step(6);

    IO_mode = 4'b1001; IO_input = 4'b0000; step(3);
    pulse0(20, 4'b0000); step(4);

    IO_mode = 4'b0000; step(2);
    IO_mode = 4'b1001; step(2);
    pulse0(5, 4'b0000); step(4);
    IO_mode = 4'b1111; step(10);
    IO_input = 4'b0001; step(10);

    IO_mode = 4'b1101; IO_input = 4'b0000; step(4);
    for (int k = 0; k < 2; k++) begin
      IO_input = 4'b0100; step(1);
      IO_input = 4'b0000; step(4);
    end

    IO_mode = 4'b1010; IO_input = 4'b0010; step(4);
    pulse0(3, 4'b0010); step(4);

    IO_mode = 4'b1001; IO_input = 4'b0000; step(2);
    pulse0(3, 4'b0000); step(4);
    reset = 1'b0; step(1);
    reset = 1'b1; step(2);
    pulse0(4, 4'b0000); step(4);

    IO_mode = 4'b1100; step(30);
    IO_mode = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      IO_input = 4'($urandom_range(0, 15)); step(1);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) IO_mode = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) reset = 1'b0;
      else reset = 1'b1;
      IO_input = 4'($urandom_range(0, 15));
      step(1);
    end

    reset = 1'b1;
    for (int m = 8; m < 16; m++) begin
      IO_mode = 4'(m);
      for (int i = 0; i < 25; i++) begin
        IO_input = 4'($urandom_range(0, 15)); step(1);
      end
    end

    step(2);
    checks = checks + 1;
    if (exp_q.size() > 1) begin
      errors = errors + 1;
      $display("FAIL queue_drain got=%0d exp<=1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
